// File: rtl/led_frame_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_frame_seq_if
//  Description : Bundle of the frame-request, pixel-RAM and serialiser
//                command signals used by led_frame_seq.
//                master = the sequencer, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_frame_seq_if #(
    parameter int ADDR_W = 6
);
    logic              frame_start;   // request one strip update
    logic              frame_busy;    // update in progress
    logic              frame_done;    // one-cycle completion pulse
    logic              ack_error;     // sticky serialiser ack timeout
    logic [ADDR_W-1:0] pix_addr;      // pixel RAM read address
    logic              pix_rd;        // pixel RAM read strobe
    logic [23:0]       pix_data;      // {red, green, blue}, valid 1 cycle after pix_rd
    logic [7:0]        blue_output;
    logic [7:0]        green_output;
    logic [7:0]        red_output;
    logic [1:0]        type_output;   // 0=start, 1=led, 2=end
    logic              doled_start;   // command strobe to serialiser
    logic              doled_busy;    // serialiser busy

    modport master (
        input  frame_start, pix_data, doled_busy,
        output frame_busy, frame_done, ack_error, pix_addr, pix_rd,
               blue_output, green_output, red_output, type_output, doled_start
    );

    modport slave (
        output frame_start, pix_data, doled_busy,
        input  frame_busy, frame_done, ack_error, pix_addr, pix_rd,
               blue_output, green_output, red_output, type_output, doled_start
    );
endinterface
`default_nettype wire

// File: rtl/led_frame_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_frame_seq
//  Description : Sequences one LED strip update per frame_start: a start
//                frame, NUM_LEDS pixel frames fetched from pixel RAM in
//                address order, then ceil(NUM_LEDS/16) end frames. Each
//                frame is handed to the serialiser with a one-cycle
//                doled_start and a handshake on doled_busy (rise = ack,
//                fall = done). A missing ack within ACK_TIMEOUT cycles
//                aborts the update and sets the sticky ack_error.
//  Ports       : ledseq_clk   - clock, rising edge
//                ledseq_reset - asynchronous active-high reset
//                bus          - led_frame_seq_if.master (request, status,
//                               pixel RAM read port, serialiser command)
//  Revision    : 1.0 - initial release
// ============================================================================
module led_frame_seq #(
    parameter int NUM_LEDS    = 60,
    parameter int ADDR_W      = 6,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic       ledseq_clk,
    input  wire logic       ledseq_reset,
    led_frame_seq_if.master bus
);

    localparam int c_END_FRAMES = (NUM_LEDS + 15) / 16;
    localparam int c_IDX_W      = (NUM_LEDS > 1)     ? $clog2(NUM_LEDS)     : 1;
    localparam int c_END_W      = (c_END_FRAMES > 1) ? $clog2(c_END_FRAMES) : 1;
    localparam int c_TMO_W      = (ACK_TIMEOUT > 1)  ? $clog2(ACK_TIMEOUT)  : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_LEDS - 1);
    localparam logic [c_END_W-1:0] c_LAST_END = c_END_W'(c_END_FRAMES - 1);
    localparam logic [c_TMO_W-1:0] c_LAST_TMO = c_TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_ACK   = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_FETCH      = 3'd4,
        ST_FETCH_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_START = 2'd0,
        PH_LED   = 2'd1,
        PH_END   = 2'd2
    } phase_t;

    state_t             state_q,       state_d;
    phase_t             phase_q,       phase_d;
    logic [c_IDX_W-1:0] led_idx_q,     led_idx_d;
    logic [c_END_W-1:0] end_cnt_q,     end_cnt_d;
    logic [c_TMO_W-1:0] tmo_cnt_q,     tmo_cnt_d;
    logic               frame_busy_q,  frame_busy_d;
    logic               frame_done_q,  frame_done_d;
    logic               ack_error_q,   ack_error_d;
    logic               pix_rd_q,      pix_rd_d;
    logic [ADDR_W-1:0]  pix_addr_q,    pix_addr_d;
    logic [7:0]         red_q,         red_d;
    logic [7:0]         green_q,       green_d;
    logic [7:0]         blue_q,        blue_d;
    logic [1:0]         type_q,        type_d;
    logic               doled_start_q, doled_start_d;

    logic [c_IDX_W-1:0] w_idx_inc;
    assign w_idx_inc = led_idx_q + c_IDX_W'(1);

    always_ff @(posedge ledseq_clk or posedge ledseq_reset) begin
        if (ledseq_reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_START;
            led_idx_q     <= '0;
            end_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            frame_busy_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            ack_error_q   <= 1'b0;
            pix_rd_q      <= 1'b0;
            pix_addr_q    <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            type_q        <= '0;
            doled_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            led_idx_q     <= led_idx_d;
            end_cnt_q     <= end_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frame_busy_q  <= frame_busy_d;
            frame_done_q  <= frame_done_d;
            ack_error_q   <= ack_error_d;
            pix_rd_q      <= pix_rd_d;
            pix_addr_q    <= pix_addr_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            type_q        <= type_d;
            doled_start_q <= doled_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        led_idx_d     = led_idx_q;
        end_cnt_d     = end_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        frame_busy_d  = frame_busy_q;
        frame_done_d  = 1'b0;
        ack_error_d   = ack_error_q;
        pix_rd_d      = 1'b0;
        pix_addr_d    = pix_addr_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        type_d        = type_q;
        doled_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // frame_start is only looked at here, so requests made
                // while an update is running are dropped, not queued.
                if (bus.frame_start) begin
                    frame_busy_d = 1'b1;
                    phase_d      = PH_START;
                    type_d       = 2'd0;
                    red_d        = '0;
                    green_d      = '0;
                    blue_d       = '0;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A serialiser still busy from elsewhere just delays the command.
                if (!bus.doled_busy) begin
                    doled_start_d = 1'b1;
                    tmo_cnt_d     = '0;
                    state_d       = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (bus.doled_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == c_LAST_TMO) begin
                    ack_error_d  = 1'b1;
                    frame_busy_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!bus.doled_busy) begin
                    case (phase_q)
                        PH_START: begin
                            phase_d    = PH_LED;
                            led_idx_d  = '0;
                            pix_addr_d = '0;
                            pix_rd_d   = 1'b1;
                            state_d    = ST_FETCH;
                        end
                        PH_LED: begin
                            if (led_idx_q != c_LAST_IDX) begin
                                led_idx_d  = w_idx_inc;
                                pix_addr_d = ADDR_W'(w_idx_inc);
                                pix_rd_d   = 1'b1;
                                state_d    = ST_FETCH;
                            end else begin
                                phase_d   = PH_END;
                                end_cnt_d = '0;
                                type_d    = 2'd2;
                                red_d     = '0;
                                green_d   = '0;
                                blue_d    = '0;
                                state_d   = ST_ISSUE;
                            end
                        end
                        PH_END: begin
                            if (end_cnt_q != c_LAST_END) begin
                                end_cnt_d = end_cnt_q + c_END_W'(1);
                                state_d   = ST_ISSUE;
                            end else begin
                                frame_done_d = 1'b1;
                                frame_busy_d = 1'b0;
                                state_d      = ST_IDLE;
                            end
                        end
                        default: begin
                            frame_busy_d = 1'b0;
                            state_d      = ST_IDLE;
                        end
                    endcase
                end
            end

            // pix_rd/pix_addr were registered on entry, so the strobe is
            // high for exactly this one cycle.
            ST_FETCH: begin
                state_d = ST_FETCH_WAIT;
            end

            // RAM data arrives one cycle after the strobe.
            ST_FETCH_WAIT: begin
                red_d   = bus.pix_data[23:16];
                green_d = bus.pix_data[15:8];
                blue_d  = bus.pix_data[7:0];
                type_d  = 2'd1;
                state_d = ST_ISSUE;
            end

            default: begin
                frame_busy_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    assign bus.frame_busy   = frame_busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.ack_error    = ack_error_q;
    assign bus.pix_rd       = pix_rd_q;
    assign bus.pix_addr     = pix_addr_q;
    assign bus.red_output   = red_q;
    assign bus.green_output = green_q;
    assign bus.blue_output  = blue_q;
    assign bus.type_output  = type_q;
    assign bus.doled_start  = doled_start_q;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_frame_seq
//  Description : Self-checking bench for led_frame_seq. Two instances
//                (NUM_LEDS=3 and NUM_LEDS=17) share clock and reset, each
//                with its own serialiser and pixel RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_seq;

    localparam int c_ACK_TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_frame_seq_if #(.ADDR_W(2)) if3 ();
    led_frame_seq_if #(.ADDR_W(5)) if17 ();

    led_frame_seq #(.NUM_LEDS(3), .ADDR_W(2), .ACK_TIMEOUT(c_ACK_TO)) dut3 (
        .ledseq_clk   (clk),
        .ledseq_reset (rst),
        .bus          (if3)
    );

    led_frame_seq #(.NUM_LEDS(17), .ADDR_W(5), .ACK_TIMEOUT(c_ACK_TO)) dut17 (
        .ledseq_clk   (clk),
        .ledseq_reset (rst),
        .bus          (if17)
    );

    // ---------------- environment state ----------------
    logic [1:0]  fstart    = '0;
    logic [1:0]  never_ack = '0;
    logic [1:0]  hold_busy = '0;
    logic [1:0]  busy_r    = '0;
    logic [1:0]  s_act     = '0;
    int          s_t   [2];
    int          dly   [2];
    int          len   [2];
    int          n_done[2];
    int          n_bad_done[2];
    int          n_rd  [2];
    int          n_start[2];
    logic [23:0] ram [2][32];
    logic [25:0] got0[$];
    logic [25:0] got1[$];
    logic [25:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    assign if3.frame_start  = fstart[0];
    assign if17.frame_start = fstart[1];
    assign if3.doled_busy   = busy_r[0];
    assign if17.doled_busy  = busy_r[1];

    wire [1:0] done_w   = {if17.frame_done,  if3.frame_done};
    wire [1:0] fbusy_w  = {if17.frame_busy,  if3.frame_busy};
    wire [1:0] err_w    = {if17.ack_error,   if3.ack_error};
    wire [1:0] dstart_w = {if17.doled_start, if3.doled_start};
    wire [1:0] rd_w     = {if17.pix_rd,      if3.pix_rd};

    logic [25:0] cmd_w  [2];
    logic [35:0] outs_w [2];
    assign cmd_w[0]  = {if3.type_output,  if3.red_output,  if3.green_output,  if3.blue_output};
    assign cmd_w[1]  = {if17.type_output, if17.red_output, if17.green_output, if17.blue_output};
    assign outs_w[0] = {if3.frame_busy, if3.frame_done, if3.ack_error, if3.pix_rd,
                        3'b000, if3.pix_addr, cmd_w[0], if3.doled_start};
    assign outs_w[1] = {if17.frame_busy, if17.frame_done, if17.ack_error, if17.pix_rd,
                        if17.pix_addr, cmd_w[1], if17.doled_start};

    // Synchronous pixel RAM: data is valid only in the cycle after pix_rd,
    // garbage otherwise.
    always @(posedge clk) begin
        if3.pix_data  <= if3.pix_rd  ? ram[0][if3.pix_addr]  : 24'($urandom);
        if17.pix_data <= if17.pix_rd ? ram[1][if17.pix_addr] : 24'($urandom);
    end

    // Serialiser model + command monitor, evaluated on the falling edge.
    // After a doled_start, busy rises dly cycles later and stays for len cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                s_act[k]  = 1'b0;
                s_t[k]    = 0;
                busy_r[k] = 1'b0;
            end else begin
                if (dstart_w[k]) begin
                    n_start[k]++;
                    if (k == 0) got0.push_back(cmd_w[0]);
                    else        got1.push_back(cmd_w[1]);
                    if (!never_ack[k]) begin
                        s_act[k] = 1'b1;
                        s_t[k]   = 0;
                    end
                end else if (s_act[k]) begin
                    s_t[k]++;
                end
                if (s_act[k] && s_t[k] >= dly[k] + len[k]) s_act[k] = 1'b0;
                busy_r[k] = hold_busy[k] | (s_act[k] && s_t[k] >= dly[k] && s_t[k] < dly[k] + len[k]);
                if (done_w[k]) begin
                    n_done[k]++;
                    if (fbusy_w[k]) n_bad_done[k]++;
                end
                if (rd_w[k]) n_rd[k]++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act_v, exp_v);
        end
    endtask

    function automatic int n_leds(input int sel);
        return (sel == 0) ? 3 : 17;
    endfunction

    // Reference: one start, every pixel in address order, ceil(N/16) ends.
    task automatic build_exp(input int sel);
        int n    = n_leds(sel);
        int ends = (n + 15) / 16;
        exp_q.delete();
        exp_q.push_back({2'd0, 24'h000000});
        for (int i = 0; i < n; i++) exp_q.push_back({2'd1, ram[sel][i]});
        for (int e = 0; e < ends; e++) exp_q.push_back({2'd2, 24'h000000});
    endtask

    task automatic setup_frame(input int sel, input int d, input int l, input bit rnd);
        if (rnd) for (int i = 0; i < n_leds(sel); i++) ram[sel][i] = 24'($urandom);
        dly[sel] = d;
        len[sel] = l;
        build_exp(sel);
        if (sel == 0) got0.delete(); else got1.delete();
        n_done[sel]     = 0;
        n_bad_done[sel] = 0;
        n_rd[sel]       = 0;
        n_start[sel]    = 0;
    endtask

    task automatic pulse_start(input int sel);
        fstart[sel] = 1'b1;
        tick(1);
        fstart[sel] = 1'b0;
    endtask

    task automatic finish_frame(input int sel, input bit mid, input int exp_cmds, input bit exp_err);
        int cyc = 0;
        int bad = 0;
        int gsz;
        logic [25:0] g;
        while (n_done[sel] == 0 && fbusy_w[sel] && cyc < 3000) begin
            // a request in the middle of an update must be dropped
            fstart[sel] = mid && (cyc == 20);
            tick(1);
            cyc++;
        end
        fstart[sel] = 1'b0;
        check("frame_within_budget", (cyc < 3000), 1);
        tick(8);
        gsz = (sel == 0) ? got0.size() : got1.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < gsz) ? ((sel == 0) ? got0[i] : got1[i]) : 26'h3FFFFFF;
            if (g !== exp_q[i]) bad++;
        end
        check("cmd_count",       gsz,              exp_cmds);
        check("cmd_seq_errors",  bad,              0);
        check("start_pulses",    n_start[sel],     exp_cmds);
        check("frame_done_cnt",  n_done[sel],      1);
        check("busy_at_done",    n_bad_done[sel],  0);
        check("pix_rd_cnt",      n_rd[sel],        n_leds(sel));
        check("ack_error",       err_w[sel],       exp_err);
        check("idle_after",      fbusy_w[sel],     0);
    endtask

    task automatic run_frame(input int sel, input int d, input int l, input bit mid,
                             input bit rnd, input int exp_cmds, input bit exp_err);
        setup_frame(sel, d, l, rnd);
        pulse_start(sel);
        check("busy_after_start", fbusy_w[sel], 1);
        finish_frame(sel, mid, exp_cmds, exp_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    typedef struct {
        int sel;
        int dly;
        int len;
        bit mid;
        int exp_cmds;
    } vec_t;

    // ---------------- test sequence ----------------
    initial begin
        vec_t tbl[5];
        int   cyc;
        logic [25:0] g;

        tbl[0] = '{0, 1, 10, 1'b0, 5};
        tbl[1] = '{1, 1, 1,  1'b0, 20};
        tbl[2] = '{1, 15, 3, 1'b1, 20};   // ack on the last allowed wait cycle
        tbl[3] = '{0, 8, 1,  1'b1, 5};
        tbl[4] = '{1, 2, 6,  1'b0, 20};

        for (int k = 0; k < 2; k++) begin
            dly[k] = 1; len[k] = 1; s_t[k] = 0;
            n_done[k] = 0; n_bad_done[k] = 0; n_rd[k] = 0; n_start[k] = 0;
        end
        rst = 1'b1;
        tick(1);
        check("reset_outs_n3",  outs_w[0], 0);
        check("reset_outs_n17", outs_w[1], 0);
        do_reset();
        check("post_reset_outs_n3",  outs_w[0], 0);
        check("post_reset_outs_n17", outs_w[1], 0);

        // Known RAM pattern on the 3-LED strip.
        ram[0][0] = 24'hFF0000;
        ram[0][1] = 24'h00FF00;
        ram[0][2] = 24'h0000FF;
        run_frame(0, 1, 10, 1'b0, 1'b0, 5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            g = (i < got0.size()) ? got0[i] : 26'h3FFFFFF;
            case (i)
                0: check("n3_cmd0_start", g, {2'd0, 24'h000000});
                1: check("n3_cmd1_red",   g, {2'd1, 24'hFF0000});
                2: check("n3_cmd2_green", g, {2'd1, 24'h00FF00});
                3: check("n3_cmd3_blue",  g, {2'd1, 24'h0000FF});
                default: check("n3_cmd4_end", g, {2'd2, 24'h000000});
            endcase
        end

        // Table of frame scenarios.
        for (int v = 0; v < 5; v++)
            run_frame(tbl[v].sel, tbl[v].dly, tbl[v].len, tbl[v].mid, 1'b1, tbl[v].exp_cmds, 1'b0);

        // Randomised frames.
        for (int r = 0; r < 6; r++) begin
            int sel = int'($urandom_range(0, 1));
            run_frame(sel, int'($urandom_range(1, 15)), int'($urandom_range(1, 12)),
                      1'($urandom_range(0, 1)), 1'b1, (sel == 0) ? 5 : 20, 1'b0);
        end

        // Serialiser busy when the request is accepted: first command waits.
        hold_busy[0] = 1'b1;
        setup_frame(0, 1, 10, 1'b1);
        pulse_start(0);
        tick(20);
        check("held_no_start",   n_start[0], 0);
        check("held_still_busy", fbusy_w[0], 1);
        hold_busy[0] = 1'b0;
        tick(4);
        check("held_one_start",  n_start[0], 1);
        finish_frame(0, 1'b0, 5, 1'b0);

        // Serialiser never acknowledges.
        never_ack[0] = 1'b1;
        setup_frame(0, 1, 1, 1'b1);
        pulse_start(0);
        cyc = 0;
        while (!dstart_w[0] && cyc < 50) begin
            tick(1);
            cyc++;
        end
        check("tmo_saw_start", dstart_w[0], 1);
        tick(c_ACK_TO - 1);
        check("tmo_err_before",  err_w[0],   0);
        check("tmo_busy_before", fbusy_w[0], 1);
        tick(1);
        check("tmo_err_set",     err_w[0],   1);
        check("tmo_busy_clear",  fbusy_w[0], 0);
        tick(3);
        check("tmo_no_done",     n_done[0],  0);
        never_ack[0] = 1'b0;
        run_frame(0, 2, 4, 1'b0, 1'b1, 5, 1'b1);   // accepted; error stays sticky
        do_reset();
        check("err_cleared_by_reset", err_w[0], 0);

        // Reset during the second LED command on the 17-LED strip.
        setup_frame(1, 1, 10, 1'b1);
        pulse_start(1);
        cyc = 0;
        while (got1.size() < 3 && cyc < 500) begin
            fstart[1] = (got1.size() == 2);
            tick(1);
            cyc++;
        end
        fstart[1] = 1'b0;
        check("rst_reached_led2", got1.size(), 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outs_n17", outs_w[1], 0);
        check("rst_async_outs_n3",  outs_w[0], 0);
        tick(2);
        rst = 1'b0;
        n_start[1] = 0;
        tick(12);
        check("rst_no_more_start", n_start[1], 0);
        check("rst_idle",          fbusy_w[1], 0);
        run_frame(1, 3, 5, 1'b0, 1'b1, 20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
